// File: rtl/mii_rx_deframer.sv
// rtl/mii_rx_deframer.sv - 4-bit MII receive to byte-wide frame stream deframer
module mii_rx_deframer #(
    parameter int MIN_PREAMBLE_NIBBLES = 2,
    parameter int MAX_FRAME_BYTES      = 1522
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] mii_rxd,
    input  logic       mii_rx_dv,
    input  logic       mii_rx_er,
    output logic       out_frame_valid,
    output logic       out_data_valid,
    output logic       out_error,
    output logic [7:0] out_data,
    output logic       drop_pulse
);
    localparam int BW = $clog2(MAX_FRAME_BYTES + 1);
    localparam int NW = $clog2(MIN_PREAMBLE_NIBBLES + 2);
    localparam logic [BW-1:0] MAX_CNT = BW'(MAX_FRAME_BYTES);
    localparam logic [NW-1:0] MIN_CNT = NW'(MIN_PREAMBLE_NIBBLES);

    typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_LOW, S_HIGH, S_DROP} state_t;

    state_t        r_state;
    logic [3:0]    r_rxd;
    logic [3:0]    r_lo;
    logic          r_dv;
    logic          r_er;
    logic          r_dv_prev;
    logic          r_in_valid;
    logic [NW-1:0] r_pre_cnt;
    logic [BW-1:0] r_byte_cnt;
    logic          w_dv_rise;

    assign w_dv_rise = r_dv & ~r_dv_prev;

    // r_dv holds a reset value, not a real sample, on the first edge after reset;
    // keep r_dv_prev high until r_dv is genuine so a frame already in flight is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rxd      <= 4'h0;
            r_dv       <= 1'b0;
            r_er       <= 1'b0;
            r_dv_prev  <= 1'b1;
            r_in_valid <= 1'b0;
        end else begin
            r_rxd      <= mii_rxd;
            r_dv       <= mii_rx_dv;
            r_er       <= mii_rx_er;
            r_dv_prev  <= r_in_valid ? r_dv : 1'b1;
            r_in_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_lo            <= 4'h0;
            r_pre_cnt       <= '0;
            r_byte_cnt      <= '0;
            out_frame_valid <= 1'b0;
            out_data_valid  <= 1'b0;
            out_error       <= 1'b0;
            out_data        <= 8'h00;
            drop_pulse      <= 1'b0;
        end else begin
            out_data_valid <= 1'b0;
            drop_pulse     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    out_frame_valid <= 1'b0;
                    out_error       <= 1'b0;
                    if (w_dv_rise) begin
                        if (r_rxd == 4'h5) begin
                            r_pre_cnt <= NW'(1);
                            r_state   <= S_PREAMBLE;
                        end else begin
                            r_state <= S_DROP;
                        end
                    end
                end
                S_PREAMBLE: begin
                    if (!r_dv) begin
                        drop_pulse <= 1'b1;
                        r_state    <= S_IDLE;
                    end else if (r_rxd == 4'h5) begin
                        if (r_pre_cnt < MIN_CNT)
                            r_pre_cnt <= r_pre_cnt + NW'(1);
                    end else if (r_rxd == 4'hD && r_pre_cnt >= MIN_CNT) begin
                        out_frame_valid <= 1'b1;
                        r_byte_cnt      <= '0;
                        r_state         <= S_LOW;
                    end else begin
                        drop_pulse <= 1'b1;
                        r_state    <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (!r_dv)
                        r_state <= S_IDLE;
                end
                S_LOW: begin
                    if (!r_dv) begin
                        out_frame_valid <= 1'b0;
                        out_error       <= 1'b0;
                        r_state         <= S_IDLE;
                    end else begin
                        r_lo <= r_rxd;
                        if (r_er)
                            out_error <= 1'b1;
                        r_state <= S_HIGH;
                    end
                end
                S_HIGH: begin
                    if (!r_dv) begin
                        // Odd nibble count: hold frame_valid one more cycle with error set.
                        out_error <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        if (r_er)
                            out_error <= 1'b1;
                        if (r_byte_cnt == MAX_CNT) begin
                            out_error <= 1'b1;
                        end else begin
                            out_data       <= {r_rxd, r_lo};
                            out_data_valid <= 1'b1;
                            r_byte_cnt     <= r_byte_cnt + BW'(1);
                        end
                        r_state <= S_LOW;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/mii_rx_deframer.md
# mii_rx_deframer

Converts the receive side of a 4-bit MII PHY interface into the team's byte-wide frame stream. It strips the preamble and SFD, assembles nibbles into bytes and flags error conditions on the stream's `error` line. It sits directly upstream of every frame-stream consumer (FCS checker, MAC filter) and runs in the PHY RX clock domain. There is no backpressure: output rate is fixed by the line.

## Interface
Parameters:
- `MIN_PREAMBLE_NIBBLES`, default 2: minimum count of 0x5 nibbles required before the SFD nibble 0xD.
- `MAX_FRAME_BYTES`, default 1522: maximum post-SFD byte count, including FCS. Byte counter width is $clog2(MAX_FRAME_BYTES+1).

Ports:
- `clk`  in  1: MII RX clock (25 MHz at 100 Mb/s); only clock.
- `rst`  in  1: asynchronous, active-high reset.
- `mii_rxd`  in  4: receive nibble.
- `mii_rx_dv`  in  1: receive data valid.
- `mii_rx_er`  in  1: receive error.
- `out_frame_valid`  out  1: frame stream `frame_valid`.
- `out_data_valid`  out  1: frame stream `data_valid`.
- `out_error`  out  1: frame stream `error`.
- `out_data`  out  8: frame stream `data`.
- `drop_pulse`  out  1: one-cycle pulse when a preamble is rejected and no frame is emitted.

## Operation
- Input stage: `mii_rxd`, `mii_rx_dv` and `mii_rx_er` are registered once (r_rxd, r_dv, r_er). r_dv_prev holds the previous r_dv. All decisions use the registered values.
- FSM states: IDLE, PREAMBLE, LOW, HIGH, DROP.
- IDLE: enters PREAMBLE on an r_dv rising edge (r_dv=1, r_dv_prev=0); r_er is ignored. A nibble counter loads 1 if r_rxd=0x5, otherwise the FSM goes to DROP.
- PREAMBLE:
  - r_dv=0: go to IDLE, pulse `drop_pulse`.
  - r_rxd=0x5: increment the nibble counter (saturating).
  - r_rxd=0xD with count ≥ MIN_PREAMBLE_NIBBLES: go to LOW and assert `out_frame_valid`.
  - Any other nibble, or SFD too early: go to DROP and pulse `drop_pulse`.
- DROP: no output activity. Returns to IDLE when r_dv=0.
- LOW: latch r_rxd as byte bits [3:0], then go to HIGH.
- HIGH: `out_data` = {r_rxd, latched low nibble}. `out_data_valid` pulses for one cycle and the byte counter increments. Then go to LOW.
- Nibble order is low nibble first, per the MII standard.
- Length: once the byte counter equals MAX_FRAME_BYTES, further completed bytes do not assert `out_data_valid` and set `out_error`.
- Errors:
  - r_er=1 in LOW or HIGH sets `out_error`.
  - r_dv falling while in HIGH (odd nibble count) sets `out_error`.
  - `out_error` is sticky until the frame ends.
- Frame end (r_dv=0 in LOW or HIGH):
  - Clean end (in LOW, no error): `out_frame_valid` drops at the next edge.
  - Odd end (in HIGH): one extra cycle with `out_frame_valid`=1, `out_error`=1, `out_data_valid`=0. Then `out_frame_valid` and `out_error` drop together.
  - The FSM returns to IDLE either way.
- A new frame requires a fresh r_dv rising edge plus at least one preamble nibble. This guarantees `out_frame_valid` is low for at least one cycle between frames.

## Timing
- Reset values:
  - All outputs 0; FSM in IDLE; counters 0; r_rxd, r_dv, r_er 0.
  - r_dv_prev resets to 1, so a frame already in progress at reset release is ignored until `mii_rx_dv` goes low.
- Reset asserted mid-frame: all outputs clear asynchronously. This truncates the frame without `out_error`; consumers must treat a frame_valid drop caused by reset as abort.
- Latency: a nibble sampled on pins at edge E reaches r_* at edge E. The corresponding output change registers at edge E+1, giving 1 cycle from input register to output.
- `out_frame_valid` rises at the edge after the SFD nibble is in r_rxd.
- `out_data_valid` is high at most every other cycle, for exactly one cycle per byte.
- `out_data` holds its value until the next byte. It is don't-care when `out_data_valid`=0 but must not be X after reset.
- `out_data_valid` and `out_error` never assert while `out_frame_valid`=0.

## Test plan
- Clean frame: dv high with 15×0x5 + 0xD, then nibbles 0x1,0x2,0x3,0x4; dv low.
  - Required: frame_valid high, then bytes 0x21 and 0x43 with data_valid on alternate cycles, error=0.
  - frame_valid low 1 cycle after dv is registered low.
- rx_er mid-frame: same frame with er=1 on the nibble 0x3.
  - Required: error high from the following edge until frame_valid falls; both fall on the same edge.
- Odd nibble end: 0x5,0x5,0xD then nibbles 0xA,0xB,0xC; dv low.
  - Required: byte 0xBA emitted, then one cycle with frame_valid=1, error=1, data_valid=0, then all low.
- Bad preamble: dv high with 0x5 then 0x7, and separately 0xD with only 1×0x5 preceding (MIN_PREAMBLE_NIBBLES=2).
  - Required: a `drop_pulse` per frame and no frame_valid.
- Length limit: MAX_FRAME_BYTES=4, send 6 bytes.
  - Required: exactly 4 data_valid pulses, error set on the 5th byte slot, frame_valid held until dv low.
- Reset: assert rst during byte 2, release while dv is still high.
  - Required: outputs 0 immediately; the remainder of that frame is ignored; the next full frame is received correctly.
